branch_resolver: RTL and testbench

//   Execute-stage consumer of the branch condition result. Accepts a resolved-operand branch from decode,

---
 rtl/branch_resolver_pkg.sv | 26 ++
 rtl/branch_resolver_cond.sv | 33 +++
 rtl/branch_resolver.sv | 135 +++++++++++++
 tb/tb_branch_resolver.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolver_pkg.sv
// Shared definitions for the branch resolution unit: condition-code encodings,
// PC step, default counter width and the stage-1 request record.
package branch_resolver_pkg;

    localparam logic [2:0] BR_OP_EQ  = 3'b000;
    localparam logic [2:0] BR_OP_GE  = 3'b001;
    localparam logic [2:0] BR_OP_LE  = 3'b010;
    localparam logic [2:0] BR_OP_GT  = 3'b011;
    localparam logic [2:0] BR_OP_LT  = 3'b100;
    localparam logic [2:0] BR_OP_NE  = 3'b101;
    localparam logic [2:0] BR_OP_AL  = 3'b110;
    localparam logic [2:0] BR_OP_ILL = 3'b111;

    localparam logic [31:0] PC_STEP       = 32'd4;
    localparam int          CNT_W_DEFAULT = 32;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pc;
        logic [31:0] offset;
        logic        pred;
    } br_req_t;

endpackage

// File: rtl/branch_resolver_cond.sv
// Pure combinational branch condition evaluator: (op, a, b) -> (taken, illegal).
// Operands are compared unsigned.
module branch_cond
    import branch_resolver_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic        o_taken,
    output logic        o_illegal
);

    // Decode the condition code into the branch outcome
    always_comb begin
        o_taken   = 1'b0;
        o_illegal = 1'b0;
        case (i_op)
            BR_OP_EQ:  o_taken = (i_a == i_b);
            BR_OP_GE:  o_taken = (i_a >= i_b);
            BR_OP_LE:  o_taken = (i_a <= i_b);
            BR_OP_GT:  o_taken = (i_a >  i_b);
            BR_OP_LT:  o_taken = (i_a <  i_b);
            BR_OP_NE:  o_taken = (i_a != i_b);
            BR_OP_AL:  o_taken = 1'b1;
            BR_OP_ILL: o_illegal = 1'b1;
            default: begin
                o_taken   = 1'b0;
                o_illegal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/branch_resolver.sv
// Execute-stage branch resolver: stage-1 capture, condition evaluation, redirect
// and predictor-update pulses, saturating performance counters.
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEFAULT,
    parameter int PC_ALIGN = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             br_valid,
    output logic             br_ready,
    input  logic [2:0]       br_op,
    input  logic [31:0]      br_a,
    input  logic [31:0]      br_b,
    input  logic [31:0]      br_pc,
    input  logic [31:0]      br_offset,
    input  logic             br_pred_taken,
    input  logic             hold,
    input  logic             flush,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             upd_valid,
    output logic [31:0]      upd_pc,
    output logic             upd_taken,
    output logic             illegal_op,
    output logic [CNT_W-1:0] cnt_branches,
    output logic [CNT_W-1:0] cnt_mispred
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             r_s1_valid;
    br_req_t          r_s1;
    logic             r_redirect_valid;
    logic [31:0]      r_redirect_pc;
    logic             r_upd_valid;
    logic [31:0]      r_upd_pc;
    logic             r_upd_taken;
    logic             r_illegal;
    logic [CNT_W-1:0] r_cnt_branches;
    logic [CNT_W-1:0] r_cnt_mispred;

    br_req_t     w_req;
    logic        w_accept;
    logic        w_resolve;
    logic        w_taken;
    logic        w_illegal;
    logic        w_mispred;
    logic [31:0] w_target;
    logic [31:0] w_fallthru;

    branch_cond u_cond (
        .i_op      (r_s1.op),
        .i_a       (r_s1.a),
        .i_b       (r_s1.b),
        .o_taken   (w_taken),
        .o_illegal (w_illegal)
    );

    // While a redirect is on the wire, whatever sits in S1 came from the wrong path.
    assign br_ready   = !flush && !r_redirect_valid && (!r_s1_valid || !hold);
    assign w_accept   = br_valid && br_ready;
    assign w_resolve  = r_s1_valid && !hold && !flush && !r_redirect_valid;
    assign w_mispred  = (w_taken != r_s1.pred);
    assign w_target   = r_s1.pc + (r_s1.offset << PC_ALIGN);
    assign w_fallthru = r_s1.pc + PC_STEP;

    assign w_req = '{op: br_op, a: br_a, b: br_b, pc: br_pc,
                     offset: br_offset, pred: br_pred_taken};

    // Stage-1 occupancy and captured request
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1       <= '0;
        end else if (flush || r_redirect_valid) begin
            r_s1_valid <= 1'b0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1       <= w_req;
        end else if (w_resolve) begin
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= r_s1_valid;
        end
    end

    // Resolve stage: one-cycle pulses plus their payloads
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= 32'd0;
            r_upd_valid      <= 1'b0;
            r_upd_pc         <= 32'd0;
            r_upd_taken      <= 1'b0;
            r_illegal        <= 1'b0;
        end else begin
            r_upd_valid      <= w_resolve;
            r_redirect_valid <= w_resolve && w_mispred;
            r_illegal        <= w_resolve && w_illegal;
            if (w_resolve) begin
                r_upd_pc      <= r_s1.pc;
                r_upd_taken   <= w_taken;
                r_redirect_pc <= w_taken ? w_target : w_fallthru;
            end
        end
    end

    // Saturating counters advance with the pulses they count
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt_branches <= '0;
            r_cnt_mispred  <= '0;
        end else begin
            if (w_resolve && (r_cnt_branches != CNT_MAX)) begin
                r_cnt_branches <= r_cnt_branches + CNT_ONE;
            end
            if (w_resolve && w_mispred && (r_cnt_mispred != CNT_MAX)) begin
                r_cnt_mispred <= r_cnt_mispred + CNT_ONE;
            end
        end
    end

    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign upd_valid      = r_upd_valid;
    assign upd_pc         = r_upd_pc;
    assign upd_taken      = r_upd_taken;
    assign illegal_op     = r_illegal;
    assign cnt_branches   = r_cnt_branches;
    assign cnt_mispred    = r_cnt_mispred;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed scoreboard bench for branch_resolver; a second instance with 2-bit
// counters shares the stimulus to exercise saturation.
module tb_branch_resolver;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        br_valid, br_pred_taken, hold, flush;
    logic [2:0]  br_op;
    logic [31:0] br_a, br_b, br_pc, br_offset;

    logic        br_ready, redirect_valid, upd_valid, upd_taken, illegal_op;
    logic [31:0] redirect_pc, upd_pc, cnt_branches, cnt_mispred;

    logic        br_ready2, redirect_valid2, upd_valid2, upd_taken2, illegal_op2;
    logic [31:0] redirect_pc2, upd_pc2;
    logic [1:0]  cnt_branches2, cnt_mispred2;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic        red;
        logic [31:0] rpc;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_br   = 0;
    int   exp_mp   = 0;

    branch_resolver #(.CNT_W(32), .PC_ALIGN(2)) dut (
        .clock(clock), .reset_n(reset_n), .br_valid(br_valid), .br_ready(br_ready),
        .br_op(br_op), .br_a(br_a), .br_b(br_b), .br_pc(br_pc), .br_offset(br_offset),
        .br_pred_taken(br_pred_taken), .hold(hold), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .illegal_op(illegal_op), .cnt_branches(cnt_branches), .cnt_mispred(cnt_mispred)
    );

    branch_resolver #(.CNT_W(2), .PC_ALIGN(2)) dut_sat (
        .clock(clock), .reset_n(reset_n), .br_valid(br_valid), .br_ready(br_ready2),
        .br_op(br_op), .br_a(br_a), .br_b(br_b), .br_pc(br_pc), .br_offset(br_offset),
        .br_pred_taken(br_pred_taken), .hold(hold), .flush(flush),
        .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2),
        .upd_valid(upd_valid2), .upd_pc(upd_pc2), .upd_taken(upd_taken2),
        .illegal_op(illegal_op2), .cnt_branches(cnt_branches2), .cnt_mispred(cnt_mispred2)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic model_taken(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
        case (op)
            3'b000:  return a == b;
            3'b001:  return a >= b;
            3'b010:  return a <= b;
            3'b011:  return a > b;
            3'b100:  return a < b;
            3'b101:  return a != b;
            3'b110:  return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int sat3(input int n);
        return (n > 3) ? 3 : n;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Drive one request for one edge; optionally record its expected resolution.
    task automatic present(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] pc, input logic [31:0] off, input logic pred,
                           input bit push);
        exp_t e;
        br_valid = 1'b1; br_op = op; br_a = a; br_b = b;
        br_pc = pc; br_offset = off; br_pred_taken = pred;
        #1;
        check("accept_ready", {31'd0, br_ready}, 32'd1);
        if (push) begin
            e.pc    = pc;
            e.taken = model_taken(op, a, b);
            e.red   = (e.taken != pred);
            e.rpc   = e.taken ? (pc + {off[29:0], 2'b00}) : (pc + 32'd4);
            e.ill   = (op == 3'b111);
            sb.push_back(e);
            exp_br++;
            if (e.red) exp_mp++;
        end
        step();
    endtask

    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] pc, input logic [31:0] off, input logic pred);
        present(op, a, b, pc, off, pred, 1'b1);
        br_valid = 1'b0;
        step();
        step();
    endtask

    // Scoreboard: every resolve pulse must match the oldest expected branch
    always @(negedge clock) begin
        if (reset_n === 1'b1) begin
            if (upd_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_upd", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("upd_pc", upd_pc, e.pc);
                    check("upd_taken", {31'd0, upd_taken}, {31'd0, e.taken});
                    check("redirect_valid", {31'd0, redirect_valid}, {31'd0, e.red});
                    if (e.red) check("redirect_pc", redirect_pc, e.rpc);
                    check("illegal_op", {31'd0, illegal_op}, {31'd0, e.ill});
                end
            end else if ((redirect_valid !== 1'b0) || (illegal_op !== 1'b0)) begin
                check("stray_pulse", {30'd0, redirect_valid, illegal_op}, 32'd0);
            end
        end
    end

    initial begin
        reset_n = 1'b0; br_valid = 1'b0; hold = 1'b0; flush = 1'b0;
        br_op = 3'b000; br_a = 32'd0; br_b = 32'd0; br_pc = 32'd0;
        br_offset = 32'd0; br_pred_taken = 1'b0;
        step();
        step();
        check("rst_upd_valid", {31'd0, upd_valid}, 32'd0);
        check("rst_redirect", {31'd0, redirect_valid}, 32'd0);
        check("rst_redirect_pc", redirect_pc, 32'd0);
        check("rst_upd_pc", upd_pc, 32'd0);
        check("rst_cnt_br", cnt_branches, 32'd0);
        check("rst_ready", {31'd0, br_ready}, 32'd1);
        reset_n = 1'b1;
        step();

        // Directed resolves: taken redirect, no redirect, wraparound fallthru and target
        send(3'b000, 32'd5, 32'd5, 32'h100, 32'd4, 1'b0);
        send(3'b011, 32'd3, 32'd7, 32'h104, 32'd8, 1'b0);
        check("cnt_br_t2", cnt_branches, 32'd2);
        check("cnt_mp_t2", cnt_mispred, 32'd1);
        check("sat_br_t2", {30'd0, cnt_branches2}, 32'd2);
        send(3'b101, 32'd1, 32'd1, 32'hFFFF_FFFC, 32'd2, 1'b1);
        check("cnt_mp_t3", cnt_mispred, 32'd2);
        send(3'b000, 32'd7, 32'd7, 32'hFFFF_FFF0, 32'd8, 1'b0);

        // Back-to-back, all correctly predicted; unsigned edges on GE/LT
        present(3'b001, 32'd9, 32'd9, 32'h200, 32'hFFFF_FFFC, 1'b1, 1'b1);
        present(3'b010, 32'd10, 32'd4, 32'h204, 32'd4, 1'b0, 1'b1);
        present(3'b100, 32'd2, 32'd9, 32'h208, 32'd4, 1'b1, 1'b1);
        present(3'b001, 32'd1, 32'hFFFF_FFFF, 32'h300, 32'd4, 1'b0, 1'b1);
        present(3'b100, 32'h8000_0000, 32'd1, 32'h304, 32'd4, 1'b0, 1'b1);
        present(3'b110, 32'd0, 32'd0, 32'h20C, 32'h10, 1'b1, 1'b1);
        br_valid = 1'b0;
        step();
        step();

        // Self-squash: mispredicting A, then B accepted the next edge is discarded
        present(3'b000, 32'd1, 32'd2, 32'h400, 32'd4, 1'b1, 1'b1);
        present(3'b110, 32'd0, 32'd0, 32'h404, 32'd4, 1'b1, 1'b0);
        br_valid = 1'b0;
        #1;
        check("squash_ready", {31'd0, br_ready}, 32'd0);
        check("squash_redirect", {31'd0, redirect_valid}, 32'd1);
        step();
        step();
        check("squash_ready_after", {31'd0, br_ready}, 32'd1);

        // Hold with S1 full for three cycles, then a single resolve
        present(3'b110, 32'd0, 32'd0, 32'h500, 32'd3, 1'b1, 1'b1);
        br_valid = 1'b0;
        hold = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("hold_ready", {31'd0, br_ready}, 32'd0);
            step();
            check("hold_no_pulse", {31'd0, upd_valid}, 32'd0);
        end
        hold = 1'b0;
        step();
        check("hold_release_pulse", {31'd0, upd_valid}, 32'd1);
        hold = 1'b1;
        step();
        check("pulse_drops_in_hold", {31'd0, upd_valid}, 32'd0);
        check("empty_ready_in_hold", {31'd0, br_ready}, 32'd1);
        hold = 1'b0;
        step();

        // Flush with S1 full; a same-cycle request must be refused
        present(3'b110, 32'd0, 32'd0, 32'h5A0, 32'd4, 1'b0, 1'b0);
        flush = 1'b1;
        br_op = 3'b110; br_pc = 32'h5B0; br_pred_taken = 1'b0;
        #1;
        check("flush_ready", {31'd0, br_ready}, 32'd0);
        step();
        flush = 1'b0;
        br_valid = 1'b0;
        #1;
        check("flush_s1_empty", {31'd0, br_ready}, 32'd1);
        step();
        step();

        // Illegal op, with and without a prediction mismatch
        send(3'b111, 32'd0, 32'd0, 32'h600, 32'd4, 1'b1);
        send(3'b111, 32'd3, 32'd3, 32'h700, 32'd4, 1'b0);

        check("sb_drained", sb.size(), 32'd0);
        check("cnt_br_final", cnt_branches, exp_br);
        check("cnt_mp_final", cnt_mispred, exp_mp);
        check("sat_br_final", {30'd0, cnt_branches2}, sat3(exp_br));
        check("sat_mp_final", {30'd0, cnt_mispred2}, sat3(exp_mp));

        // Reset mid-operation: live pulse and occupied S1 are both discarded
        present(3'b110, 32'd0, 32'd0, 32'h800, 32'd4, 1'b1, 1'b0);
        present(3'b110, 32'd0, 32'd0, 32'h804, 32'd4, 1'b1, 1'b0);
        br_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        check("midrst_upd", {31'd0, upd_valid}, 32'd0);
        check("midrst_cnt", cnt_branches, 32'd0);
        check("midrst_ready", {31'd0, br_ready}, 32'd1);
        step();
        reset_n = 1'b1;
        step();
        step();
        check("post_rst_no_upd", {31'd0, upd_valid}, 32'd0);
        check("post_rst_cnt", cnt_branches, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
